mips_data_mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of mips_data_mem.
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA port.
- Accepts one transaction at a time, drives the memory's address/data/opcode/sig_mem_read/sig_mem_write for a fixed access window, captures read_data and returns a one-cycle ack.

---
 rtl/mips_mem_pkg.sv | 43 ++++
 rtl/mips_rr_arbiter2.sv | 22 ++
 rtl/mips_data_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mips_data_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the mips_data_mem arbiter: MIPS memory opcodes,
// sequencer state encoding and opcode/alignment classification helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==00.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return |a;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-way round-robin winner select. Purely combinational; the caller owns
// the last_grant register. On a tie the requester that did not win last wins.
module mips_rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_id_o    = 1'b0;
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_grant_i;
        end else if (req1_i) begin
            gnt_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// Round-robin arbiter and sequencer in front of mips_data_mem.
// Requester 0 = core LSU, requester 1 = debug/DMA. One transaction at a time:
// IDLE (grant + latch) -> ACCESS (ACCESS_CYCLES cycles of strobes) -> RESP (ack).
// Optional build macro MIPS_MEM_ARB_ALIGN_CHECK_EN: misaligned halfword/word
// transactions skip ACCESS and are acked with err=1, rdata=0.
// Handshake: a requester holds req and its fields stable until its one-cycle
// ack; req still high at the edge ending the ack cycle is a new request.
// dbg_state_o exposes the sequencer state for observation.
module mips_data_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [5:0]  m0_opcode,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [5:0]  m1_opcode,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic [5:0]  opcode,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data,
    output logic [1:0]  dbg_state_o
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [31:0] cap;
    logic        gnt_valid, gnt_id;
    logic [5:0]  sel_op;
    logic [31:0] sel_addr;
`ifdef MIPS_MEM_ARB_ALIGN_CHECK_EN
    logic        err_q, err_d;
`endif

    mips_rr_arbiter2 u_arb (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    assign sel_op   = gnt_id ? m1_opcode : m0_opcode;
    assign sel_addr = gnt_id ? m1_addr   : m0_addr;

    // Next-state: grant and latch in IDLE, count down in ACCESS, ack in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cap          = 32'h0;
`ifdef MIPS_MEM_ARB_ALIGN_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    op_d    = sel_op;
                    addr_d  = sel_addr;
                    wdata_d = gnt_id ? m1_wdata : m0_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
`ifdef MIPS_MEM_ARB_ALIGN_CHECK_EN
                    err_d   = 1'b0;
                    if (is_misaligned(sel_op, sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                        if (gnt_id) rdata1_d = 32'h0;
                        else        rdata0_d = 32'h0;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    // Loads capture memory; unknown opcodes return 0; stores leave rdata.
                    if (is_load(op_q)) cap = read_data;
                    if (!is_store(op_q)) begin
                        if (id_q) rdata1_d = cap;
                        else      rdata0_d = cap;
                    end
                end
            end
            ST_RESP: begin
                last_grant_d = id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            id_q         <= 1'b0;
            op_q         <= 6'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef MIPS_MEM_ARB_ALIGN_CHECK_EN
    // Error flag for the transaction currently being acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign m0_err = m0_ack & err_q;
    assign m1_err = m1_ack & err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    // Memory drive: fields hold outside ACCESS, strobes only while in ACCESS.
    assign mem_address   = addr_q;
    assign write_data    = wdata_q;
    assign opcode        = op_q;
    assign sig_mem_read  = (state_q == ST_ACCESS) && is_load(op_q);
    assign sig_mem_write = (state_q == ST_ACCESS) && is_store(op_q);

    assign m0_ack      = (state_q == ST_RESP) && !id_q;
    assign m1_ack      = (state_q == ST_RESP) &&  id_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Directed bench for mips_data_mem_arbiter: instance a uses ACCESS_CYCLES=1,
// instance b uses ACCESS_CYCLES=4. Each instance has a small word memory.
module tb_mips_data_mem_arbiter;
    import mips_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, rst4_n;

    // ---------------- instance a signals ----------------
    logic        a_m0_req, a_m1_req, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
    logic [5:0]  a_m0_op, a_m1_op, a_op;
    logic [31:0] a_m0_addr, a_m1_addr, a_m0_wd, a_m1_wd, a_m0_rd, a_m1_rd;
    logic [31:0] a_mem_addr, a_wdata, a_read_data;
    logic        a_rd_s, a_wr_s;
    logic [1:0]  a_dbg;

    // ---------------- instance b signals ----------------
    logic        b_m0_req, b_m1_req, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
    logic [5:0]  b_m0_op, b_m1_op, b_op;
    logic [31:0] b_m0_addr, b_m1_addr, b_m0_wd, b_m1_wd, b_m0_rd, b_m1_rd;
    logic [31:0] b_mem_addr, b_wdata, b_read_data;
    logic        b_rd_s, b_wr_s;
    logic [1:0]  b_dbg;

    mips_data_mem_arbiter #(.ACCESS_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(a_m0_req), .m0_opcode(a_m0_op), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wd),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rd), .m0_err(a_m0_err),
        .m1_req(a_m1_req), .m1_opcode(a_m1_op), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wd),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rd), .m1_err(a_m1_err),
        .mem_address(a_mem_addr), .write_data(a_wdata), .opcode(a_op),
        .sig_mem_read(a_rd_s), .sig_mem_write(a_wr_s), .read_data(a_read_data),
        .dbg_state_o(a_dbg)
    );

    mips_data_mem_arbiter #(.ACCESS_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .m0_req(b_m0_req), .m0_opcode(b_m0_op), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wd),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rd), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_opcode(b_m1_op), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wd),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rd), .m1_err(b_m1_err),
        .mem_address(b_mem_addr), .write_data(b_wdata), .opcode(b_op),
        .sig_mem_read(b_rd_s), .sig_mem_write(b_wr_s), .read_data(b_read_data),
        .dbg_state_o(b_dbg)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    assign a_read_data = mem_a[a_mem_addr[7:2]];
    assign b_read_data = mem_b[b_mem_addr[7:2]];
    always @(posedge clk) if (a_wr_s) mem_a[a_mem_addr[7:2]] = a_wdata;
    always @(posedge clk) if (b_wr_s) mem_b[b_mem_addr[7:2]] = b_wdata;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_mis = 0;
    logic [33:0] exp_a_q[$];   // {err, id, rdata}
    logic [33:0] exp_b_q[$];
    logic [33:0] ea, eb;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Monitor: every ack pops the oldest expected response for that instance.
    initial begin
        forever begin
            @(negedge clk);
            if (a_m0_ack || a_m1_ack) begin
                check("a_double_ack", {31'b0, a_m0_ack & a_m1_ack}, 32'd0);
                if (exp_a_q.size() == 0) begin
                    check("a_unexpected_ack", {31'b0, a_m1_ack}, {31'b0, ~a_m1_ack});
                end else begin
                    ea = exp_a_q.pop_front();
                    check("a_ack_id", {31'b0, a_m1_ack}, {31'b0, ea[32]});
                    check("a_rdata", a_m1_ack ? a_m1_rd : a_m0_rd, ea[31:0]);
                    check("a_err", {31'b0, a_m1_ack ? a_m1_err : a_m0_err}, {31'b0, ea[33]});
                end
            end
            if (b_m0_ack || b_m1_ack) begin
                check("b_double_ack", {31'b0, b_m0_ack & b_m1_ack}, 32'd0);
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_ack", {31'b0, b_m1_ack}, {31'b0, ~b_m1_ack});
                end else begin
                    eb = exp_b_q.pop_front();
                    check("b_ack_id", {31'b0, b_m1_ack}, {31'b0, eb[32]});
                    check("b_rdata", b_m1_ack ? b_m1_rd : b_m0_rd, eb[31:0]);
                    check("b_err", {31'b0, b_m1_ack ? b_m1_err : b_m0_err}, {31'b0, eb[33]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_a(input logic id, input logic r, input logic [5:0] op,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (!id) begin
            a_m0_req = r; a_m0_op = op; a_m0_addr = ad; a_m0_wd = wd;
        end else begin
            a_m1_req = r; a_m1_op = op; a_m1_addr = ad; a_m1_wd = wd;
        end
    endtask

    task automatic set_b(input logic id, input logic r, input logic [5:0] op,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (!id) begin
            b_m0_req = r; b_m0_op = op; b_m0_addr = ad; b_m0_wd = wd;
        end else begin
            b_m1_req = r; b_m1_op = op; b_m1_addr = ad; b_m1_wd = wd;
        end
    endtask

    // Wait (bounded) for requester id's ack on instance a, then drop its req.
    task automatic wait_ack_a(input logic id);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (id ? a_m1_ack : a_m0_ack) ok = 1'b1;
        end
        check("a_ack_timeout", {31'b0, ok}, 32'd1);
        if (!id) a_m0_req = 1'b0;
        else     a_m1_req = 1'b0;
    endtask

    // Issue one transaction on instance a and wait for its ack.
    task automatic txn_a(input logic id, input logic [5:0] op, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        set_a(id, 1'b1, op, ad, wd);
        exp_a_q.push_back({exp_err, id, exp_rd});
        wait_ack_a(id);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, last, nack;
        logic got0, got1;

        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[0] = 32'hA5A5_0011;
        mem_a[1] = 32'h1234_5678;
        mem_b[0] = 32'h0000_BEEF;
        mem_b[1] = 32'hCAFE_0001;
        rst_n = 1'b0; rst4_n = 1'b0;
        set_a(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        set_a(1'b1, 1'b0, 6'd0, 32'h0, 32'h0);
        set_b(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        set_b(1'b1, 1'b0, 6'd0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_acks", {28'b0, a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}, 32'd0);
        check("rst_errs", {28'b0, a_m0_err, a_m1_err, b_m0_err, b_m1_err}, 32'd0);
        check("rst_strobes", {28'b0, a_rd_s, a_wr_s, b_rd_s, b_wr_s}, 32'd0);
        check("rst_rdata", a_m0_rd | a_m1_rd | b_m0_rd | b_m1_rd, 32'd0);
        check("rst_mem_addr", a_mem_addr | b_mem_addr, 32'd0);
        check("rst_wdata", a_wdata | b_wdata, 32'd0);
        check("rst_opcode", {20'b0, a_op, b_op}, 32'd0);
        check("rst_state", {28'b0, a_dbg, b_dbg}, {28'b0, ST_IDLE, ST_IDLE});
        rst_n = 1'b1; rst4_n = 1'b1;

        // m0 lw 0x4 -> 0x12345678
        set_a(1'b0, 1'b1, OP_LW, 32'h4, 32'h0);
        exp_a_q.push_back({1'b0, 1'b0, 32'h1234_5678});
        @(negedge clk);
        check("lw_read_strobe", {30'b0, a_rd_s, a_wr_s}, 32'd2);
        check("lw_mem_addr", a_mem_addr, 32'h4);
        check("lw_opcode", {26'b0, a_op}, {26'b0, OP_LW});
        check("lw_no_early_ack", {30'b0, a_m0_ack, a_m1_ack}, 32'd0);
        @(negedge clk);
        check("lw_ack", {29'b0, a_m0_ack, a_m1_ack, a_rd_s}, 32'd4);
        a_m0_req = 1'b0;
        @(negedge clk);
        check("lw_rdata_held", a_m0_rd, 32'h1234_5678);
        check("lw_ack_one_cycle", {31'b0, a_m0_ack}, 32'd0);

        // m1 sw 0x8, then m0 lw 0x8 reads it back
        set_a(1'b1, 1'b1, OP_SW, 32'h8, 32'h7FFF_FFFC);
        exp_a_q.push_back({1'b0, 1'b1, 32'h0});
        @(negedge clk);
        check("sw_write_strobe", {30'b0, a_rd_s, a_wr_s}, 32'd1);
        check("sw_mem_addr", a_mem_addr, 32'h8);
        check("sw_write_data", a_wdata, 32'h7FFF_FFFC);
        @(negedge clk);
        check("sw_ack", {29'b0, a_m0_ack, a_m1_ack, a_wr_s}, 32'd2);
        a_m1_req = 1'b0;
        @(negedge clk);
        txn_a(1'b0, OP_LW, 32'h8, 32'h0, 32'h7FFF_FFFC, 1'b0);

        // Unknown opcode: no strobes, still acked, rdata cleared
        set_a(1'b0, 1'b1, 6'b000000, 32'hC, 32'h0);
        exp_a_q.push_back({1'b0, 1'b0, 32'h0});
        @(negedge clk);
        @(negedge clk);
        check("badop_state", {30'b0, a_dbg}, {30'b0, ST_ACCESS});
        check("badop_no_strobe", {30'b0, a_rd_s, a_wr_s}, 32'd0);
        wait_ack_a(1'b0);

        // Both requesting from reset: alternate 0,1,0,1, one ack per 3 cycles
        @(negedge clk);
        rst_n = 1'b0;
        set_a(1'b0, 1'b1, OP_LBU, 32'h1, 32'h0);
        set_a(1'b1, 1'b1, OP_SB, 32'h5, 32'h55);
        exp_a_q.push_back({1'b0, 1'b0, 32'hA5A5_0011});
        exp_a_q.push_back({1'b0, 1'b1, 32'h0});
        exp_a_q.push_back({1'b0, 1'b0, 32'hA5A5_0011});
        exp_a_q.push_back({1'b0, 1'b1, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; last = -1; nack = 0;
        for (int i = 0; i < 30 && nack < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (a_m0_ack || a_m1_ack) begin
                if (last >= 0) check("tie_ack_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                nack++;
                if (nack == 4) begin
                    a_m0_req = 1'b0;
                    a_m1_req = 1'b0;
                end
            end
        end
        check("tie_ack_count", 32'(nack), 32'd4);

        // ACCESS_CYCLES=4: lhu 0x2, addr change mid-access is ignored
        set_b(1'b0, 1'b1, OP_LHU, 32'h2, 32'h0);
        exp_b_q.push_back({1'b0, 1'b0, 32'h0000_BEEF});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                check("ac4_read_strobe", {30'b0, b_rd_s, b_m0_ack}, 32'd2);
                check("ac4_mem_addr", b_mem_addr, 32'h2);
                if (i == 2) b_m0_addr = 32'h6;
            end else begin
                check("ac4_ack_5th", {30'b0, b_rd_s, b_m0_ack}, 32'd1);
                b_m0_req = 1'b0;
            end
        end

        // Reset in the 2nd ACCESS cycle of a store: strobes drop, no ack
        @(negedge clk);
        set_b(1'b0, 1'b1, OP_SW, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_pre_wr", {31'b0, b_wr_s}, 32'd1);
        rst4_n = 1'b0;
        b_m0_req = 1'b0;
        #1;
        check("rst_mid_strobes", {30'b0, b_rd_s, b_wr_s}, 32'd0);
        check("rst_mid_state", {30'b0, b_dbg}, {30'b0, ST_IDLE});
        check("rst_mid_acks", {30'b0, b_m0_ack, b_m1_ack}, 32'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        set_b(1'b0, 1'b1, OP_LW, 32'h0, 32'h0);
        set_b(1'b1, 1'b1, OP_LW, 32'h4, 32'h0);
        exp_b_q.push_back({1'b0, 1'b0, 32'h0000_BEEF});
        exp_b_q.push_back({1'b0, 1'b1, 32'hCAFE_0001});
        got0 = 1'b0; got1 = 1'b0;
        for (int i = 0; i < 40 && !(got0 && got1); i++) begin
            @(negedge clk);
            if (b_m0_ack) begin got0 = 1'b1; b_m0_req = 1'b0; end
            if (b_m1_ack) begin got1 = 1'b1; b_m1_req = 1'b0; end
        end
        check("post_rst_both_acked", {30'b0, got0, got1}, 32'd3);

`ifdef MIPS_MEM_ARB_ALIGN_CHECK_EN
        // Misaligned lw: immediate ack with err, no strobes
        @(negedge clk);
        set_a(1'b0, 1'b1, OP_LW, 32'h6, 32'h0);
        exp_a_q.push_back({1'b1, 1'b0, 32'h0});
        @(negedge clk);
        check("mis_no_strobe", {30'b0, a_rd_s, a_wr_s}, 32'd0);
        check("mis_ack_err", {30'b0, a_m0_ack, a_m0_err}, 32'd3);
        a_m0_req = 1'b0;
        @(negedge clk);
        // Aligned sh: normal write, err=0
        set_a(1'b0, 1'b1, OP_SH, 32'h2, 32'h1234);
        exp_a_q.push_back({1'b0, 1'b0, 32'h0});
        @(negedge clk);
        check("sh_write_strobe", {31'b0, a_wr_s}, 32'd1);
        wait_ack_a(1'b0);
`endif

        repeat (3) @(negedge clk);
        check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
